// File: rtl/reg_file_param.sv
// reg_file_param: parametrised 2-read/1-write register file with per-register
// pending (scoreboard) bits and an optional hardwired zero register.
// Optional feature: define REGFILE_BYPASS_EN to forward write-port data and
// pending-clear onto the read ports in the same cycle as the write.
module reg_file_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic [ADDR_W-1:0] AddrC,
    input  logic [DATA_W-1:0] BusC,
    input  logic              SetPend,
    input  logic [ADDR_W-1:0] AddrPend,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB,
    output logic              PendA,
    output logic              PendB,
    output logic              PendAny
);

    localparam int DEPTH   = 2**ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_next;
    logic              write_ok;

    // Writes to r0 are dropped when it is the hardwired zero register.
    assign write_ok = RegWrite && !(ZERO_EN && (AddrC == '0));

    // Register array storage with asynchronous clear.
    // NOTE: the whole array is reset here because the design promises an
    // all-zero file after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: non-blocking assignment for all sequential state so
                // every flop samples pre-edge values regardless of block order.
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[AddrC] <= BusC;
        end
    end

    // Next pending vector: write clears, SetPend sets afterwards so set wins.
    always_comb begin
        // NOTE: default first so every path assigns the vector and no latch
        // is inferred.
        pend_next = pend;
        if (RegWrite) begin
            pend_next[AddrC] = 1'b0;
        end
        if (SetPend) begin
            pend_next[AddrPend] = 1'b1;
        end
        if (ZERO_EN) begin
            pend_next[0] = 1'b0;
        end
    end

    // Pending-bit scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    // Read port A: stored value, optional same-cycle forward, zero-reg and reset gating.
    always_comb begin
        BusA  = regs[AddrA];
        PendA = pend[AddrA];
`ifdef REGFILE_BYPASS_EN
        if (write_ok && (AddrA == AddrC)) begin
            BusA  = BusC;
            PendA = SetPend && (AddrPend == AddrC);
        end
`endif
        if (ZERO_EN && (AddrA == '0)) begin
            BusA  = '0;
            PendA = 1'b0;
        end
        if (rst) begin
            BusA  = '0;
            PendA = 1'b0;
        end
    end

    // Read port B: mirrors port A on its own address.
    always_comb begin
        BusB  = regs[AddrB];
        PendB = pend[AddrB];
`ifdef REGFILE_BYPASS_EN
        if (write_ok && (AddrB == AddrC)) begin
            BusB  = BusC;
            PendB = SetPend && (AddrPend == AddrC);
        end
`endif
        if (ZERO_EN && (AddrB == '0)) begin
            BusB  = '0;
            PendB = 1'b0;
        end
        if (rst) begin
            BusB  = '0;
            PendB = 1'b0;
        end
    end

    // Any register awaiting a producer; forced low while reset is asserted.
    assign PendAny = (|pend) && !rst;

endmodule
